// File: rtl/tpu_package.sv
// Shared TPU definitions: array geometry, weight-fetch FSM encoding and default read latency.
package tpu_package;

    localparam int MUL_SIZE      = 32;
    localparam int WFETCH_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        DRAIN     = 2'd2,
        WAIT_SLOT = 2'd3
    } wfetch_state_t;

endpackage

// File: rtl/wfetch_rd_pipe.sv
// Read-tag delay line: carries (valid, bank, row) of each weight-memory read alongside its
// RD_LAT-cycle memory latency so the buffer write lands with the returning data.
module wfetch_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int ROW_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_en_i,
    input  logic             issue_bank_i,
    input  logic [ROW_W-1:0] issue_row_i,
    output logic             wr_en_o,
    output logic             wr_bank_o,
    output logic [ROW_W-1:0] wr_row_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] bank_q;
    logic [ROW_W-1:0]  row_q [RD_LAT];

    // Clearing the valids on reset drops any reads still in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            bank_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= issue_en_i;
            bank_q[0] <= issue_bank_i;
            row_q[0]  <= issue_row_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                bank_q[i] <= bank_q[i-1];
                row_q[i]  <= row_q[i-1];
            end
        end
    end

    assign wr_en_o   = vld_q[RD_LAT-1];
    assign wr_bank_o = bank_q[RD_LAT-1];
    assign wr_row_o  = row_q[RD_LAT-1];

endmodule

// File: rtl/weight_fetch_scheduler.sv
// Loads weight tiles into the two ping-pong weight banks, staying at most one tile ahead of compute.
// Optional build macro WFETCH_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module weight_fetch_scheduler #(
    parameter int MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = tpu_package::WFETCH_RD_LAT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_valid_i,
    input  logic [ADDR_W-1:0]           weight_base_addr_i,
    input  logic [5:0]                  num_tiles_i,
    output logic                        instr_accept_o,
    output logic                        wmem_rd_en_o,
    output logic [ADDR_W-1:0]           wmem_addr_o,
    input  logic [MUL_SIZE*8-1:0]       wmem_rdata_i,
    output logic                        wbuf_wr_en_o,
    output logic                        wbuf_bank_o,
    output logic [$clog2(MUL_SIZE)-1:0] wbuf_row_o,
    output logic [MUL_SIZE*8-1:0]       wbuf_data_o,
    input  logic                        next_weight_tile_i,
    output logic                        compute_weights_rdy_o,
    output logic                        active_bank_o,
    output logic                        busy_o,
`ifdef WFETCH_UNDERRUN_CNT_EN
    output logic [15:0]                 underrun_cnt_o,
`endif
    output logic [1:0]                  state_o
);

    import tpu_package::*;

    localparam int ROW_W   = $clog2(MUL_SIZE);
    localparam int DRAIN_W = $clog2(RD_LAT + 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(MUL_SIZE - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_DONE = DRAIN_W'(RD_LAT);

    wfetch_state_t        state;
    logic [ADDR_W-1:0]    addr;
    logic [5:0]           num_tiles;
    logic [5:0]           tiles_done;
    logic [ROW_W-1:0]     row_cntr;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 fill_bank;
    logic [1:0]           bank_full;
    logic [1:0]           bank_full_nxt;
    logic                 active_nxt;
    logic                 fill_sel;
    logic                 other_bank;
    logic                 consume;
    logic                 drain_done;

    assign instr_accept_o = (state == IDLE);
    assign state_o        = state;
    assign wbuf_data_o    = wmem_rdata_i;
    assign other_bank     = ~fill_bank;
    assign consume        = next_weight_tile_i && bank_full[active_bank_o];
    assign drain_done     = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    // A consume and a drain completion never hit the same bank, so both apply together.
    // With both banks full the next bank to refill is the one compute frees first (active).
    always_comb begin
        bank_full_nxt = bank_full;
        active_nxt    = active_bank_o;
        if (consume) begin
            bank_full_nxt[active_bank_o] = 1'b0;
            active_nxt                   = ~active_bank_o;
        end
        if (drain_done) begin
            bank_full_nxt[fill_bank] = 1'b1;
        end
        fill_sel = (bank_full_nxt[active_nxt] && !bank_full_nxt[~active_nxt]) ? ~active_nxt : active_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                 <= IDLE;
            addr                  <= '0;
            num_tiles             <= '0;
            tiles_done            <= '0;
            row_cntr              <= '0;
            drain_cnt             <= '0;
            fill_bank             <= 1'b0;
            bank_full             <= '0;
            active_bank_o         <= 1'b0;
            compute_weights_rdy_o <= 1'b0;
            wmem_rd_en_o          <= 1'b0;
            wmem_addr_o           <= '0;
            busy_o                <= 1'b0;
        end else begin
            bank_full             <= bank_full_nxt;
            active_bank_o         <= active_nxt;
            compute_weights_rdy_o <= bank_full_nxt[active_nxt];
            case (state)
                IDLE: begin
                    if (instr_valid_i) begin
                        num_tiles  <= num_tiles_i;
                        tiles_done <= '0;
                        row_cntr   <= '0;
                        addr       <= weight_base_addr_i;
                        if (num_tiles_i != 6'd0) begin
                            fill_bank <= fill_sel;
                            busy_o    <= 1'b1;
                            if (!bank_full_nxt[fill_sel]) begin
                                state        <= FETCH;
                                wmem_rd_en_o <= 1'b1;
                                wmem_addr_o  <= weight_base_addr_i;
                                addr         <= weight_base_addr_i + 1'b1;
                            end else begin
                                state <= WAIT_SLOT;
                            end
                        end
                    end
                end
                FETCH: begin
                    if (row_cntr == ROW_LAST) begin
                        state        <= DRAIN;
                        wmem_rd_en_o <= 1'b0;
                        drain_cnt    <= '0;
                    end else begin
                        row_cntr    <= row_cntr + 1'b1;
                        wmem_addr_o <= addr;
                        addr        <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The bank is published on the last write; the next-bank decision
                    // is taken one cycle later, once that full flag is visible.
                    if (drain_cnt == DRAIN_LAST) begin
                        tiles_done <= tiles_done + 6'd1;
                        if (tiles_done + 6'd1 == num_tiles) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end else if (drain_cnt == DRAIN_DONE) begin
                        fill_bank <= other_bank;
                        row_cntr  <= '0;
                        if (!bank_full_nxt[other_bank]) begin
                            state        <= FETCH;
                            wmem_rd_en_o <= 1'b1;
                            wmem_addr_o  <= addr;
                            addr         <= addr + 1'b1;
                        end else begin
                            state <= WAIT_SLOT;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                WAIT_SLOT: begin
                    if (!bank_full_nxt[fill_bank]) begin
                        state        <= FETCH;
                        wmem_rd_en_o <= 1'b1;
                        wmem_addr_o  <= addr;
                        addr         <= addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WFETCH_UNDERRUN_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underrun_cnt_o <= '0;
        end else if (next_weight_tile_i && !bank_full[active_bank_o] && underrun_cnt_o != 16'hFFFF) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
        end
    end
`endif

    wfetch_rd_pipe #(
        .RD_LAT (RD_LAT),
        .ROW_W  (ROW_W)
    ) u_rd_pipe (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_en_i   (wmem_rd_en_o),
        .issue_bank_i (fill_bank),
        .issue_row_i  (row_cntr),
        .wr_en_o      (wbuf_wr_en_o),
        .wr_bank_o    (wbuf_bank_o),
        .wr_row_o     (wbuf_row_o)
    );

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Directed bench for weight_fetch_scheduler with a latency-modelled weight memory and
// a scoreboard of expected reads and buffer writes.
module tb_weight_fetch_scheduler;
  import tpu_package::*;

  localparam int MS     = 32;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int ROW_W  = 5;
  localparam int DW     = MS * 8;
  localparam int EW     = 1 + ROW_W + DW;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              instr_valid_i;
  logic [ADDR_W-1:0] weight_base_addr_i;
  logic [5:0]        num_tiles_i;
  logic              instr_accept_o;
  logic              wmem_rd_en_o;
  logic [ADDR_W-1:0] wmem_addr_o;
  logic [DW-1:0]     wmem_rdata_i;
  logic              wbuf_wr_en_o;
  logic              wbuf_bank_o;
  logic [ROW_W-1:0]  wbuf_row_o;
  logic [DW-1:0]     wbuf_data_o;
  logic              next_weight_tile_i;
  logic              compute_weights_rdy_o;
  logic              active_bank_o;
  logic              busy_o;
  logic [1:0]        state_o;
`ifdef WFETCH_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit saw_wait = 1'b0;

  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [EW-1:0]     exp_wr_q[$];

  weight_fetch_scheduler #(.MUL_SIZE(MS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .instr_valid_i         (instr_valid_i),
    .weight_base_addr_i    (weight_base_addr_i),
    .num_tiles_i           (num_tiles_i),
    .instr_accept_o        (instr_accept_o),
    .wmem_rd_en_o          (wmem_rd_en_o),
    .wmem_addr_o           (wmem_addr_o),
    .wmem_rdata_i          (wmem_rdata_i),
    .wbuf_wr_en_o          (wbuf_wr_en_o),
    .wbuf_bank_o           (wbuf_bank_o),
    .wbuf_row_o            (wbuf_row_o),
    .wbuf_data_o           (wbuf_data_o),
    .next_weight_tile_i    (next_weight_tile_i),
    .compute_weights_rdy_o (compute_weights_rdy_o),
    .active_bank_o         (active_bank_o),
    .busy_o                (busy_o),
`ifdef WFETCH_UNDERRUN_CNT_EN
    .underrun_cnt_o        (underrun_cnt_o),
`endif
    .state_o               (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- weight memory model ----------------
  function automatic logic [DW-1:0] pattern(input logic [ADDR_W-1:0] a);
    return {8{a, a ^ 16'h5A3C}};
  endfunction

  logic [ADDR_W-1:0] lat_a [RD_LAT];
  logic [RD_LAT-1:0] lat_v = '0;

  always @(posedge clk) begin
    lat_a[0] <= wmem_addr_o;
    lat_v[0] <= wmem_rd_en_o;
    for (int i = 1; i < RD_LAT; i++) begin
      lat_a[i] <= lat_a[i-1];
      lat_v[i] <= lat_v[i-1];
    end
  end

  assign wmem_rdata_i = (lat_v[RD_LAT-1] === 1'b1) ? pattern(lat_a[RD_LAT-1]) : '0;

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    logic [EW-1:0]     ew;
    if (rst_i === 1'b0) begin
      if (state_o === 2'(WAIT_SLOT)) saw_wait = 1'b1;
      if (wmem_rd_en_o === 1'b1) begin
        n_checks++;
        assert (exp_rd_q.size() != 0) else begin
          n_errors++;
          $error("FAIL rd_unexpected: observed read addr 0x%0h expected no read", wmem_addr_o);
        end
        if (exp_rd_q.size() != 0) begin
          ea = exp_rd_q.pop_front();
          check("rd_addr", 32'(wmem_addr_o), 32'(ea));
        end
      end
      if (wbuf_wr_en_o === 1'b1) begin
        n_checks++;
        assert (exp_wr_q.size() != 0) else begin
          n_errors++;
          $error("FAIL wr_unexpected: observed write bank %0d row %0d expected no write", wbuf_bank_o, wbuf_row_o);
        end
        if (exp_wr_q.size() != 0) begin
          ew = exp_wr_q.pop_front();
          n_checks++;
          assert ({wbuf_bank_o, wbuf_row_o, wbuf_data_o} === ew) else begin
            n_errors++;
            $error("FAIL wr_entry: observed bank %0d row %0d data %h expected bank %0d row %0d data %h",
                   wbuf_bank_o, wbuf_row_o, wbuf_data_o, ew[EW-1], ew[EW-2 -: ROW_W], ew[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Banks fill 0,1,0,... from reset, so tile t lands in bank t%2.
  task automatic issue(input logic [ADDR_W-1:0] base, input int n);
    logic [ADDR_W-1:0] a;
    weight_base_addr_i = base;
    num_tiles_i        = 6'(n);
    instr_valid_i      = 1'b1;
    check("accept", 32'(instr_accept_o), 32'd1);
    for (int t = 0; t < n; t++) begin
      for (int r = 0; r < MS; r++) begin
        a = base + ADDR_W'(t * MS + r);
        exp_rd_q.push_back(a);
        exp_wr_q.push_back({1'(t & 1), ROW_W'(r), pattern(a)});
      end
    end
    cyc = 0;
    step();
    instr_valid_i = 1'b0;
  endtask

  task automatic consume_pulse();
    next_weight_tile_i = 1'b1;
    step();
    next_weight_tile_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i              = 1'b1;
    instr_valid_i      = 1'b0;
    next_weight_tile_i = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy_o !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_idle_in_time"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int k = 0;
    while (compute_weights_rdy_o !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_rdy_in_time"}, 32'(compute_weights_rdy_o), 32'd1);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_rd_q_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({tag, "_wr_q_left"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_accept"}, 32'(instr_accept_o), 32'd1);
    check({tag, "_rd_en"}, 32'(wmem_rd_en_o), 32'd0);
    check({tag, "_wr_en"}, 32'(wbuf_wr_en_o), 32'd0);
    check({tag, "_rdy"}, 32'(compute_weights_rdy_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_active"}, 32'(active_bank_o), 32'd0);
    check({tag, "_addr"}, 32'(wmem_addr_o), 32'd0);
    check({tag, "_row"}, 32'(wbuf_row_o), 32'd0);
    check({tag, "_bank"}, 32'(wbuf_bank_o), 32'd0);
    check({tag, "_state"}, 32'(state_o), 32'(IDLE));
`ifdef WFETCH_UNDERRUN_CNT_EN
    check({tag, "_underrun"}, 32'(underrun_cnt_o), 32'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_i              = 1'b1;
    instr_valid_i      = 1'b0;
    weight_base_addr_i = '0;
    num_tiles_i        = '0;
    next_weight_tile_i = 1'b0;
    step();
    step();
    check_reset_values("por");
    rst_i = 1'b0;
    step();

    // Single tile: reads 1..32, writes 3..34, ready from 35.
    issue(16'h0100, 1);
    for (int c = 1; c <= 36; c++) begin
      check($sformatf("t1_rd_en@%0d", c), 32'(wmem_rd_en_o), 32'(c >= 1 && c <= MS));
      check($sformatf("t1_wr_en@%0d", c), 32'(wbuf_wr_en_o), 32'(c >= 1 + RD_LAT && c <= MS + RD_LAT));
      check($sformatf("t1_rdy@%0d", c), 32'(compute_weights_rdy_o), 32'(c >= MS + RD_LAT + 1));
      if (c < 36) step();
    end
    check("t1_state", 32'(state_o), 32'(IDLE));
    check("t1_busy", 32'(busy_o), 32'd0);
    check_queues_empty("t1");
    consume_pulse();
    check("t1_rdy_after_consume", 32'(compute_weights_rdy_o), 32'd0);
    check("t1_active_after_consume", 32'(active_bank_o), 32'd1);

    // Ping-pong: consume one cycle after each ready, 35 cycles per tile.
    do_reset();
    saw_wait = 1'b0;
    issue(16'h0200, 3);
    for (int k = 0; k < 3; k++) begin
      wait_rdy($sformatf("t2_tile%0d", k), 60);
      check($sformatf("t2_rdy_cycle%0d", k), 32'(cyc), 32'(35 * (k + 1)));
      step();
      consume_pulse();
      check($sformatf("t2_active%0d", k), 32'(active_bank_o), 32'((k + 1) % 2));
      check($sformatf("t2_rdy_drop%0d", k), 32'(compute_weights_rdy_o), 32'd0);
    end
    wait_idle("t2", 40);
    check("t2_no_wait_slot", 32'(saw_wait), 32'd0);
    check_queues_empty("t2");

    // Back-pressure: no consume, third tile waits for bank 0.
    do_reset();
    issue(16'h0400, 3);
    while (cyc < 72) step();
    check("t3_wait_state", 32'(state_o), 32'(WAIT_SLOT));
    check("t3_wait_rd_en", 32'(wmem_rd_en_o), 32'd0);
    check("t3_wait_rdy", 32'(compute_weights_rdy_o), 32'd1);
    check("t3_wait_busy", 32'(busy_o), 32'd1);
    while (cyc < 76) step();
    check("t3_still_wait", 32'(state_o), 32'(WAIT_SLOT));
    consume_pulse();
    check("t3_fetch_state", 32'(state_o), 32'(FETCH));
    check("t3_fetch_rd_en", 32'(wmem_rd_en_o), 32'd1);
    check("t3_fetch_addr", 32'(wmem_addr_o), 32'h0440);
    check("t3_rdy_held", 32'(compute_weights_rdy_o), 32'd1);
    check("t3_active_toggled", 32'(active_bank_o), 32'd1);
    wait_idle("t3", 60);
    check_queues_empty("t3");

    // Address wrap, then a zero-count instruction.
    do_reset();
    issue(16'hFFF0, 1);
    wait_idle("t4_wrap", 60);
    check_queues_empty("t4");
    issue(16'h1234, 0);
    check("t4_zero_busy", 32'(busy_o), 32'd0);
    check("t4_zero_state", 32'(state_o), 32'(IDLE));
    step();
    check("t4_zero_rd_en", 32'(wmem_rd_en_o), 32'd0);

    // Asynchronous reset while row 10 is being issued.
    do_reset();
    issue(16'h0800, 1);
    while (cyc < 11) step();
    check("t5_row10_addr", 32'(wmem_addr_o), 32'h080A);
    #2;
    rst_i = 1'b1;
    exp_rd_q.delete();
    exp_wr_q.delete();
    #1;
    check_reset_values("t5_async");
    step();
    step();
    #3;
    rst_i = 1'b0;
    step();
    issue(16'h0900, 1);
    check("t5_new_rd_en", 32'(wmem_rd_en_o), 32'd1);
    check("t5_new_addr", 32'(wmem_addr_o), 32'h0900);
    wait_idle("t5", 60);
    check_queues_empty("t5");

    // Underrun: consume with both banks empty changes nothing.
    do_reset();
    consume_pulse();
    check("t6_state", 32'(state_o), 32'(IDLE));
    check("t6_active", 32'(active_bank_o), 32'd0);
    check("t6_rdy", 32'(compute_weights_rdy_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
`ifdef WFETCH_UNDERRUN_CNT_EN
    check("t6_underrun_cnt", 32'(underrun_cnt_o), 32'd1);
`endif
    step();
    check("t6_rd_en", 32'(wmem_rd_en_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
